// File: rtl/pw_conv_pkg.sv
// Shared types and requantisation for the 1x1 and 3x3 conv engines.
// Define PW_CONV_RELU_EN to fuse a ReLU into requant (negative results clamp to 0).
package pw_conv_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bias add with wrap at acc_w bits, arithmetic shift by frac, saturate to width bits.
    function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                   input logic signed [63:0] bias,
                                                   input int acc_w,
                                                   input int width,
                                                   input int frac);
        logic signed [63:0] s, q, hi, lo;
        s  = acc + bias;
        s  = (s <<< (64 - acc_w)) >>> (64 - acc_w);
        q  = s >>> frac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (q > hi)
            q = hi;
        else if (q < lo)
            q = lo;
`ifdef PW_CONV_RELU_EN
        if (q < 64'sd0)
            q = 64'sd0;
`else
        q = q;
`endif
        return q;
    endfunction

endpackage

// File: rtl/pw_mac.sv
// One MAC lane: registered signed product, then first-load / accumulate.
module pw_mac
    import pw_conv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_vld,
    input  logic                    first,
    input  logic                    last,
    input  logic signed [WIDTH-1:0] ifm,
    input  logic signed [WIDTH-1:0] ker,
    output logic signed [ACC_W-1:0] acc,
    output logic                    acc_vld,
    output logic                    busy
);

    localparam int STAGES = 2;

    logic [STAGES:1]          vld_pipe, first_pipe, last_pipe;
    logic signed [2*WIDTH-1:0] prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            prod       <= '0;
            acc        <= '0;
        end else begin
            vld_pipe   <= flush ? '0 : {vld_pipe[STAGES-1:1], in_vld};
            first_pipe <= {first_pipe[STAGES-1:1], first};
            last_pipe  <= {last_pipe[STAGES-1:1], last};
            if (in_vld)
                prod <= ifm * ker;
            // Loading on the first channel avoids a clear bubble between pixels.
            if (vld_pipe[1])
                acc <= first_pipe[1] ? ACC_W'(prod) : acc + ACC_W'(prod);
        end
    end

    assign acc_vld = vld_pipe[STAGES] && last_pipe[STAGES];
    assign busy    = |vld_pipe;

endmodule

// File: rtl/pw_conv_engine.sv
// Pointwise (1x1) convolution engine: DSP_NO MAC lanes accumulate CHIN channels per pixel.
// ReLU fusion is selected at build time by PW_CONV_RELU_EN (see pw_conv_pkg).
module pw_conv_engine
    import pw_conv_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ACC_W  = 32,
    parameter int DSP_NO = 256,
    parameter int CHIN   = 64,
    parameter int WOUT   = 16,
    parameter int FRAC   = 14
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               layer_en,
    input  logic [WIDTH-1:0]                   ifm,
    input  logic                               ifm_valid,
    output logic                               ifm_ready,
    output logic [$clog2(CHIN)-1:0]            weight_addr,
    input  logic [DSP_NO-1:0][WIDTH-1:0]       kernels,
    input  logic [DSP_NO-1:0][ACC_W-1:0]       bias,
    output logic [DSP_NO-1:0][WIDTH-1:0]       ofm,
    output logic                               ofm_valid,
    output logic [$clog2(WOUT*WOUT)-1:0]       pix_index,
    input  logic                               ram_feedback,
    output logic                               layer_done,
    output logic                               layer_finish
);

    localparam int NPIX   = WOUT * WOUT;
    localparam int CHAN_W = $clog2(CHIN);
    localparam int PIX_W  = $clog2(NPIX);

    typedef struct packed {
        logic signed [WIDTH-1:0] ifm;
        logic                    first;
        logic                    last;
        logic [PIX_W-1:0]        pix;
    } beat_t;

    logic [1:0]                    state, state_nxt;
    logic [CHAN_W-1:0]             chan_cnt;
    logic [PIX_W-1:0]              pix_cnt;
    logic                          feedback_seen;
    logic                          accept, chan_wrap, last_beat, idle_entry;
    beat_t                         s1;
    logic                          s1_vld;
    logic [DSP_NO-1:0][WIDTH-1:0]  s1_ker;
    logic [PIX_W-1:0]              pix_p2, pix_p3;
    logic [DSP_NO-1:0][ACC_W-1:0]  acc;
    logic [DSP_NO-1:0]             lane_vld, lane_busy;
    logic                          acc_vld, mac_busy;
    logic [DSP_NO-1:0][WIDTH-1:0]  q;

    assign ifm_ready   = (state == ST_RUN);
    assign accept      = ifm_valid && ifm_ready && layer_en;
    assign chan_wrap   = (chan_cnt == CHAN_W'(CHIN - 1));
    assign last_beat   = accept && chan_wrap && (pix_cnt == PIX_W'(NPIX - 1));
    assign weight_addr = chan_cnt;
    assign idle_entry  = (state_nxt == ST_IDLE) && (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        if (!layer_en)
            state_nxt = ST_IDLE;
        else begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   if (last_beat) state_nxt = ST_DRAIN;
                ST_DRAIN: if (!s1_vld && !mac_busy) state_nxt = ST_DONE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            chan_cnt      <= '0;
            pix_cnt       <= '0;
            feedback_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!layer_en) begin
                chan_cnt <= '0;
                pix_cnt  <= '0;
            end else if (accept) begin
                chan_cnt <= chan_wrap ? '0 : chan_cnt + 1'b1;
                if (chan_wrap)
                    pix_cnt <= (pix_cnt == PIX_W'(NPIX - 1)) ? '0 : pix_cnt + 1'b1;
            end
            if (idle_entry)
                feedback_seen <= 1'b0;
            else if (ram_feedback)
                feedback_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= '0;
            s1_vld <= 1'b0;
            s1_ker <= '0;
            pix_p2 <= '0;
            pix_p3 <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1.ifm   <= ifm;
                s1.first <= (chan_cnt == '0);
                s1.last  <= chan_wrap;
                s1.pix   <= pix_cnt;
                s1_ker   <= kernels;
            end
            // Pixel index rides alongside the MAC lanes' product and accumulate stages.
            pix_p2 <= s1.pix;
            pix_p3 <= pix_p2;
        end
    end

    for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
        pw_mac #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk     (clk),
            .rst     (rst),
            .flush   (!layer_en),
            .in_vld  (s1_vld),
            .first   (s1.first),
            .last    (s1.last),
            .ifm     (s1.ifm),
            .ker     (s1_ker[i]),
            .acc     (acc[i]),
            .acc_vld (lane_vld[i]),
            .busy    (lane_busy[i])
        );
    end

    assign acc_vld  = &lane_vld;
    assign mac_busy = |lane_busy;

    always_comb begin
        q = '0;
        for (int i = 0; i < DSP_NO; i++)
            q[i] = WIDTH'(requant(64'($signed(acc[i])), 64'($signed(bias[i])), ACC_W, WIDTH, FRAC));
    end

    // Gating on layer_en drops an in-flight pixel on abort; ofm keeps its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofm       <= '0;
            ofm_valid <= 1'b0;
            pix_index <= '0;
        end else begin
            ofm_valid <= layer_en && acc_vld;
            if (layer_en && acc_vld) begin
                ofm       <= q;
                pix_index <= pix_p3;
            end
        end
    end

    assign layer_done   = (state == ST_DONE);
    assign layer_finish = layer_done && !feedback_seen;

endmodule
